// File: rtl/secded_decoder_pipe.sv
// ============================================================================
// secded_decoder_pipe
// ----------------------------------------------------------------------------
// Two-stage pipelined extended-Hamming (SECDED) decoder for the FEC receive
// path. One received codeword can be accepted per cycle over a valid/ready
// handshake. Each word produces corrected payload data, a single-error-
// corrected flag, a double-error-detected flag and the Hamming syndrome.
//
// Codeword layout (CODE_W = DATA_W + PAR_W + 1 bits):
//   bit 0        overall even parity over the whole codeword
//   bits 1..N    Hamming positions; power-of-two positions are check bits,
//                the rest carry data in ascending order (pos 3 -> data[0],
//                pos 5 -> data[1], pos 6 -> data[2], ...)
//
// Parameters:
//   DATA_W  payload bits per codeword
//   CNT_W   width of each error counter
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous active-high reset
//   en_i          enable; 0 stops new words being accepted
//   in_valid_i    codeword present on code_in_i
//   in_ready_o    decoder accepts a codeword this cycle
//   code_in_i     received codeword
//   out_valid_o   decoded word present
//   out_ready_i   downstream accepts the decoded word
//   data_out_o    corrected payload
//   sec_o         single error corrected
//   ded_o         uncorrectable (double) error detected
//   syndrome_o    Hamming syndrome of the word
//   cnt_clr_i     clear both error counters
//   sec_cnt_o     saturating count of corrected words
//   ded_cnt_o     saturating count of uncorrectable words
//
// Optional feature macro: SECDED_ERR_CNT_EN
//   Defined   : sec_cnt_o / ded_cnt_o count output handshakes carrying
//               sec / ded, saturating at all-ones; cnt_clr_i zeroes them and
//               has priority over a simultaneous increment.
//   Undefined : no counter logic; sec_cnt_o / ded_cnt_o are tied to zero and
//               cnt_clr_i is ignored.
// ============================================================================
module secded_decoder_pipe #(
    parameter  int DATA_W = 11,
    parameter  int CNT_W  = 16,
    // Smallest r with 2^r >= DATA_W + r + 1. The true answer is either
    // clog2(DATA_W+1) or one more, and this single expression picks the
    // right one in both cases.
    localparam int PAR_W  = $clog2(DATA_W + 1 + $clog2(DATA_W + 1)),
    localparam int N      = DATA_W + PAR_W,
    localparam int CODE_W = N + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CODE_W-1:0] code_in_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_out_o,
    output logic              sec_o,
    output logic              ded_o,
    output logic [PAR_W-1:0]  syndrome_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  sec_cnt_o,
    output logic [CNT_W-1:0]  ded_cnt_o
);

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic              s1Valid_q;
    logic [CODE_W-1:0] s1Code_q;
    logic [CODE_W-1:0] s1Code_d;
    logic [PAR_W-1:0]  s1Syn_q;
    logic [PAR_W-1:0]  s1Syn_d;
    logic              s1Par_q;
    logic              s1Par_d;

    logic              s2Valid_q;
    logic [DATA_W-1:0] s2Data_q;
    logic [DATA_W-1:0] s2Data_d;
    logic              s2Sec_q;
    logic              s2Sec_d;
    logic              s2Ded_q;
    logic              s2Ded_d;
    logic [PAR_W-1:0]  s2Syn_q;

    logic              s2Ready;
    logic              s1Free;
    logic              inFire;
    logic              outFire;

    logic [PAR_W-1:0][CODE_W-1:0] synTerms;
    logic [PAR_W-1:0]             checkBits;
    logic                         unusedCheckBits;

    // ------------------------------------------------------------------------
    // Flow control. Stage 2 can take a new word when it is empty or its
    // current word leaves this cycle. Stage 1 frees up under the same
    // condition (or when it is already empty), which is what lets the
    // pipeline stream one word per cycle and still fill to two words under
    // backpressure. in_ready_o depends only on register state, en_i and
    // out_ready_i, never on in_valid_i.
    // ------------------------------------------------------------------------
    assign s2Ready    = !s2Valid_q || out_ready_i;
    assign s1Free     = !s1Valid_q || s2Ready;
    assign in_ready_o = en_i && s1Free;
    assign inFire     = in_valid_i && in_ready_o;
    assign outFire    = s2Valid_q && out_ready_i;

    // ------------------------------------------------------------------------
    // Stage 1 syndrome. Syndrome bit k is the XOR of every Hamming position
    // whose index has bit k set, which equals the XOR of the indices of all
    // set positions. The tap pattern is fixed at elaboration so no variable
    // indexing is needed. Bit 0 of the codeword never feeds the syndrome.
    // ------------------------------------------------------------------------
    genvar gk, gi;
    generate
        for (gk = 0; gk < PAR_W; gk++) begin : g_synBit
            assign synTerms[gk][0] = 1'b0;
            for (gi = 1; gi < CODE_W; gi++) begin : g_pos
                if (((gi >> gk) & 1) == 1) begin : g_tap
                    assign synTerms[gk][gi] = code_in_i[gi];
                end else begin : g_noTap
                    assign synTerms[gk][gi] = 1'b0;
                end
            end
            assign s1Syn_d[gk] = ^synTerms[gk];
        end
    endgenerate

    // Overall parity spans all CODE_W bits, including the parity bit itself,
    // so a clean word always gives 0 here.
    assign s1Par_d  = ^code_in_i;
    assign s1Code_d = code_in_i;

    // ------------------------------------------------------------------------
    // Stage 1 register. A new word is captured on the input handshake; when
    // the slot frees without a new word arriving it simply goes empty. While
    // stalled the whole stage holds.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1Valid_q <= 1'b0;
            s1Code_q  <= '0;
            s1Syn_q   <= '0;
            s1Par_q   <= 1'b0;
        end else if (s1Free) begin
            s1Valid_q <= inFire;
            if (inFire) begin
                s1Code_q <= s1Code_d;
                s1Syn_q  <= s1Syn_d;
                s1Par_q  <= s1Par_d;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 classification from the registered syndrome and parity.
    // An odd parity means an odd number of flips, taken as a single error:
    // a zero syndrome points at the parity bit, a syndrome inside 1..N points
    // at the flipped position, and a syndrome beyond N cannot come from one
    // flip so it is reported as uncorrectable. Even parity with a non-zero
    // syndrome is the classic double error. sec and ded are exclusive by
    // construction.
    // ------------------------------------------------------------------------
    always_comb begin
        s2Sec_d = 1'b0;
        s2Ded_d = 1'b0;
        if (s1Par_q) begin
            if (int'(s1Syn_q) > N) begin
                s2Ded_d = 1'b1;
            end else begin
                s2Sec_d = 1'b1;
            end
        end else if (s1Syn_q != '0) begin
            s2Ded_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Correction and payload extraction. A data position is flipped only when
    // parity is odd and the syndrome names exactly that position, which
    // leaves data untouched for clean words, parity-bit errors, double errors
    // and out-of-range syndromes. Data index of position p is p minus the
    // number of powers of two up to p, minus one.
    // Check-bit positions and bit 0 carry no payload; they are gathered into
    // a reduction that nothing consumes so they read as deliberately dropped.
    // ------------------------------------------------------------------------
    generate
        for (gi = 1; gi < CODE_W; gi++) begin : g_extract
            if ((gi & (gi - 1)) != 0) begin : g_data
                assign s2Data_d[gi - $clog2(gi + 1) - 1] =
                    s1Code_q[gi] ^ (s1Par_q && (s1Syn_q == PAR_W'(gi)));
            end else begin : g_check
                assign checkBits[$clog2(gi)] = s1Code_q[gi];
            end
        end
    endgenerate

    assign unusedCheckBits = ^{checkBits, s1Code_q[0]};

    // ------------------------------------------------------------------------
    // Stage 2 register, which also drives the outputs. It loads whenever it
    // can accept (empty or handing off this cycle); if stage 1 is empty at
    // that moment only the valid drops and the old values stay. While
    // out_valid is high and out_ready is low nothing here changes, so the
    // presented word is stable for the whole stall.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2Valid_q <= 1'b0;
            s2Data_q  <= '0;
            s2Sec_q   <= 1'b0;
            s2Ded_q   <= 1'b0;
            s2Syn_q   <= '0;
        end else if (s2Ready) begin
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                s2Data_q <= s2Data_d;
                s2Sec_q  <= s2Sec_d;
                s2Ded_q  <= s2Ded_d;
                s2Syn_q  <= s1Syn_q;
            end
        end
    end

    assign out_valid_o = s2Valid_q;
    assign data_out_o  = s2Data_q;
    assign sec_o       = s2Sec_q;
    assign ded_o       = s2Ded_q;
    assign syndrome_o  = s2Syn_q;

`ifdef SECDED_ERR_CNT_EN
    logic [CNT_W-1:0] secCnt_q;
    logic [CNT_W-1:0] secCnt_d;
    logic [CNT_W-1:0] dedCnt_q;
    logic [CNT_W-1:0] dedCnt_d;

    // ------------------------------------------------------------------------
    // Error counters. They count words actually handed downstream, so a
    // stalled word is counted once, when it finally leaves. Both saturate at
    // all-ones, and a clear overrides any increment in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        secCnt_d = secCnt_q;
        dedCnt_d = dedCnt_q;
        if (cnt_clr_i) begin
            secCnt_d = '0;
            dedCnt_d = '0;
        end else if (outFire) begin
            if (s2Sec_q && (secCnt_q != '1)) begin
                secCnt_d = secCnt_q + CNT_W'(1);
            end
            if (s2Ded_q && (dedCnt_q != '1)) begin
                dedCnt_d = dedCnt_q + CNT_W'(1);
            end
        end
    end

    // Counter registers, cleared by reset like the rest of the datapath.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            secCnt_q <= '0;
            dedCnt_q <= '0;
        end else begin
            secCnt_q <= secCnt_d;
            dedCnt_q <= dedCnt_d;
        end
    end

    assign sec_cnt_o = secCnt_q;
    assign ded_cnt_o = dedCnt_q;
`else
    logic unusedCounterInputs;

    // Without the counter feature the count outputs are constant zero; the
    // clear input and the output handshake have no consumer.
    assign sec_cnt_o           = '0;
    assign ded_cnt_o           = '0;
    assign unusedCounterInputs = cnt_clr_i ^ outFire;
`endif

endmodule

// File: doc/secded_decoder_pipe.md
Name: secded_decoder_pipe

Overview:
Parametrised, pipelined extended-Hamming (SECDED) decoder for the FEC receive path. Accepts one demodulated codeword per cycle over a valid/ready handshake, then emits corrected payload data. Flags single-error correction and double-error detection per word and reports the syndrome. Generalises the fixed 16/11 decoder to any data width and adds flow control, status outputs and optional error counters.

Parameters:
DATA_W, 11, payload bits per codeword.
CNT_W, 16, width of each error counter (counters exist only with the optional feature).
Derived localparams:
- PAR_W: smallest r with 2^r >= DATA_W+r+1.
- N = DATA_W+PAR_W.
- CODE_W = N+1.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
en  in  1  enable; 0 blocks new input acceptance.
in_valid  in  1  codeword present.
in_ready  out  1  block accepts codeword this cycle.
code_in  in  CODE_W  received codeword.
out_valid  out  1  decoded word present.
out_ready  in  1  downstream accepts.
data_out  out  DATA_W  corrected payload.
sec  out  1  single error corrected.
ded  out  1  uncorrectable error detected.
syndrome  out  PAR_W  Hamming syndrome of this word.
cnt_clr  in  1  clear error counters (feature only).
sec_cnt  out  CNT_W  corrected-word count (feature only).
ded_cnt  out  CNT_W  uncorrectable-word count (feature only).

Behaviour:
- Codeword layout:
  - bit 0 is the overall even parity bit.
  - bits 1..N are Hamming positions; positions 2^k are check bits.
  - Data occupies the remaining positions in ascending order: data_out[0] = position 3, data_out[1] = position 5, and so on.
- Stage 1 (registered on input handshake):
  - s = XOR of indices i in 1..N where code_in[i]=1.
  - p = XOR of all CODE_W bits.
  - Raw codeword is registered alongside s and p.
- Stage 2 classification:
  - s=0, p=0: clean; sec=0, ded=0.
  - p=1, s=0: bit 0 in error; data unaffected; sec=1.
  - p=1, 1<=s<=N: flip position s; sec=1.
  - p=1, s>N: ded=1; data passed uncorrected.
  - s!=0, p=0: double error; ded=1; data passed uncorrected.
  - sec and ded are never both 1.
- Latency and throughput:
  - Exactly 2 cycles from input handshake to out_valid when not stalled.
  - Sustains 1 word per cycle.
- Handshake:
  - Input handshake = in_valid & in_ready. Output handshake = out_valid & out_ready.
  - in_ready = en & (stage1 empty | stage1 advancing).
  - Stage 1 advances when stage 2 is empty or stage 2 completes its output handshake.
  - No combinational path from in_valid to in_ready.
- Stall:
  - While out_valid=1 and out_ready=0, data_out, sec, ded and syndrome hold stable.
  - Pipeline fills to 2 words, then in_ready=0.
  - No loss, no duplication, order preserved.
- en=0:
  - in_ready=0.
  - Words already in flight drain normally.
- Reset (synchronous, rst=1):
  - Clears both stage valids.
  - out_valid=0, data_out=0, sec=0, ded=0, syndrome=0, counters=0.
  - Reset mid-stream discards in-flight words.
- Simultaneous input and output handshake with pipeline full: accepted; occupancy unchanged.

Optional Feature:
Macro: SECDED_ERR_CNT_EN.
- Defined:
  - sec_cnt/ded_cnt increment by 1 on each output handshake with sec=1/ded=1 respectively.
  - Counters saturate at all-ones.
  - cnt_clr=1 zeroes both next cycle; clear wins over a simultaneous increment.
- Undefined:
  - Counter logic is omitted.
  - sec_cnt and ded_cnt are driven 0; cnt_clr is ignored.

Test Plan:
1. Clean word: DATA_W=11, code_in=16'hFFFF, out_ready=1 -> 2 cycles later data_out=11'h7FF, sec=0, ded=0, syndrome=0.
2. Single error in data position: code_in=16'hFFBF (bit 6 flipped) -> data_out=11'h7FF, sec=1, syndrome=6. Single error in overall parity bit: code_in=16'hFFFE -> data_out=11'h7FF, sec=1, syndrome=0.
3. Double error: code_in=16'h0006 -> ded=1, sec=0, syndrome=3, data_out=11'h000 (uncorrected).
4. Backpressure:
   - Stimulus: stream 16'h0000, 16'hFFFF, 16'hFFBF, 16'h0006 back-to-back; hold out_ready=0 for 3 cycles.
   - Required: in_ready=0 once 2 words are buffered; all 4 outputs appear in order with stable values during the stall; no drop.
5. Enable and reset:
   - en=0 with in_valid=1 -> in_ready=0 and no output.
   - rst=1 with 2 words in flight -> next cycle out_valid=0 and all outputs 0; the words never appear.
6. Counters (SECDED_ERR_CNT_EN, CNT_W=2):
   - 3 sec words and 2 ded words -> sec_cnt=3, ded_cnt=2.
   - 2 more sec words -> sec_cnt stays 3 (saturated).
   - cnt_clr=1 coinciding with a ded handshake -> both counters 0.
